// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-add 32x32->64 unsigned multiply sequenced over the shared ALU
module alu_mul_sequencer #(
   parameter int NUM_BITS   = 32,
   parameter int OP_BITS    = 4,
   parameter int SHIFT_BITS = 5,
   parameter int CNT_BITS   = 6
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  flush,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [NUM_BITS-1:0]   req_a,
   input  logic [NUM_BITS-1:0]   req_b,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [NUM_BITS-1:0]   resp_hi,
   output logic [NUM_BITS-1:0]   resp_lo,
   output logic                  busy,
   output logic [OP_BITS-1:0]    alu_op,
   output logic [NUM_BITS-1:0]   alu_data1,
   output logic [NUM_BITS-1:0]   alu_data2,
   output logic [SHIFT_BITS-1:0] alu_shamt,
   input  logic [NUM_BITS-1:0]   alu_result
);

   localparam logic [OP_BITS-1:0] ALU_ADD   = OP_BITS'(0);
   localparam logic [OP_BITS-1:0] ALU_PASS1 = OP_BITS'(11);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          state;
   logic [NUM_BITS-1:0] hi;
   logic [NUM_BITS-1:0] lo;
   logic [NUM_BITS-1:0] mcand;
   logic [CNT_BITS-1:0] cnt;
   logic                carry;
   logic                last_iter;

   // The ALU returns only 32 bits; a wrapped sum is smaller than hi exactly when the add overflowed.
   assign carry     = lo[0] & (alu_result < hi);
   assign last_iter = (cnt == CNT_BITS'(NUM_BITS - 1));

   assign req_ready  = (state == S_IDLE);
   assign resp_valid = (state == S_DONE);
   assign busy       = (state == S_CALC) || (state == S_DONE);
   assign resp_hi    = hi;
   assign resp_lo    = lo;
   assign alu_shamt  = '0;

   always_comb begin
      alu_op    = ALU_PASS1;
      alu_data1 = '0;
      alu_data2 = '0;
      if (state == S_CALC) begin
         alu_op    = lo[0] ? ALU_ADD : ALU_PASS1;
         alu_data1 = hi;
         alu_data2 = mcand;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state <= S_IDLE;
         hi    <= '0;
         lo    <= '0;
         mcand <= '0;
         cnt   <= '0;
      end else if (flush) begin
         state <= S_IDLE;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  hi <= '0;
                  if ((req_a != '0) && (req_b != '0)) begin
                     lo    <= req_b;
                     mcand <= req_a;
                     cnt   <= '0;
                     state <= S_CALC;
                  end else begin
                     // A zero operand makes the product zero; skip the iterations.
                     lo    <= '0;
                     state <= S_DONE;
                  end
               end
            end
            S_CALC: begin
               hi  <= {carry, alu_result[NUM_BITS-1:1]};
               lo  <= {alu_result[0], lo[NUM_BITS-1:1]};
               cnt <= cnt + 1'b1;
               if (last_iter) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (resp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
